// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencing controller:
// FSM state encoding, the wavefront flush length and a constant clog2.
package systolic_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_CLEAR = 3'd1;
  localparam logic [STATE_W-1:0] S_FEED  = 3'd2;
  localparam logic [STATE_W-1:0] S_FLUSH = 3'd3;
  localparam logic [STATE_W-1:0] S_DRAIN = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE  = 3'd5;

  // Cycles for the last wavefront to cross an n x n grid to the bottom-right PE.
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

  // Smallest r with 2**r >= value; returns at least 1 so fields never collapse.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/skew_valid_line.sv
// Skewed row-valid delay line for the systolic array.
// Lane 0 is the live input; lane i is the input delayed by i unpaused cycles.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clear        : synchronous clear of all delay stages
//   hold         : freeze the line (tracks the PE input-register pause)
//   din          : operand-issue strobe entering lane 0
//   dout[N-1:0]  : per-row valid mask
module skew_valid_line #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         hold,
  input  logic         din,
  output logic [N-1:0] dout
);

  logic [N-1:1] stage;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '0;
    end else if (clear) begin
      stage <= '0;
    end else if (!hold) begin
      for (int i = N - 1; i >= 2; i--) stage[i] <= stage[i-1];
      stage[1] <= din;
    end
  end

  // Lane 0 is combinational so row 0 is flagged in the same cycle it is issued.
  assign dout = {stage, din};

endmodule

// File: rtl/systolic_array_ctrl.sv
// Tile sequencing controller for an N x N systolic array: clears the
// accumulators, issues k_len operand slices (pausing the grid when operands
// are missing), flushes the wavefront, then drains result rows over valid/ready.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   start, k_len          : tile request and K length (latched on accept)
//   op_valid, op_rd       : operand slice present / consumed
//   k_idx                 : index of the slice being read
//   pause                 : hold for every PE input register
//   clear_acc             : one-cycle accumulator clear
//   row_en                : skewed per-row valid mask
//   out_valid, out_ready  : result row handshake; out_row is the row index
//   busy, done            : tile in progress / one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one-cycle accumulator clear
// FEED  | issuing operand slices, paused while op_valid is low
// FLUSH | 2N-1 cycles pushing zeros so the last wavefront lands
// DRAIN | grid frozen, result rows handed out one per handshake
// DONE  | one-cycle completion pulse
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int N       = 4,
  parameter int K_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [K_WIDTH-1:0]    k_len,
  input  logic                  op_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pause,
  output logic                  clear_acc,
  output logic                  op_rd,
  output logic [K_WIDTH-1:0]    k_idx,
  output logic [N-1:0]          row_en,
  output logic                  out_valid,
  output logic [clog2(N)-1:0]   out_row
);

  localparam int ROW_W     = clog2(N);
  localparam int FLUSH_LEN = flush_len(N);
  localparam int FL_W      = clog2(FLUSH_LEN);

  logic [STATE_W-1:0] state;
  logic [K_WIDTH-1:0] k_last;
  logic [FL_W-1:0]    flush_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      k_idx     <= '0;
      k_last    <= '0;
      flush_cnt <= '0;
      out_row   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k_last <= k_len - K_WIDTH'(1);
            if (k_len != '0) begin
              state <= S_CLEAR;
              // Cleared on entry so CLEAR already presents slice index 0.
              k_idx <= '0;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_CLEAR: begin
          state <= S_FEED;
        end
        S_FEED: begin
          if (op_valid) begin
            if (k_idx == k_last) begin
              state     <= S_FLUSH;
              flush_cnt <= FL_W'(FLUSH_LEN - 1);
            end else begin
              k_idx <= k_idx + K_WIDTH'(1);
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt == '0) begin
            state   <= S_DRAIN;
            out_row <= '0;
          end else begin
            flush_cnt <= flush_cnt - FL_W'(1);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_row == ROW_W'(N - 1)) begin
              state   <= S_DONE;
              out_row <= '0;
            end else begin
              out_row <= out_row + ROW_W'(1);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    pause     = 1'b0;
    clear_acc = 1'b0;
    op_rd     = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_CLEAR: begin
        busy      = 1'b1;
        clear_acc = 1'b1;
      end
      S_FEED: begin
        busy  = 1'b1;
        op_rd = op_valid;
        pause = !op_valid;
      end
      S_FLUSH: begin
        busy = 1'b1;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        pause     = 1'b1;
        out_valid = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  skew_valid_line #(.N(N)) u_skew (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state == S_CLEAR),
    .hold    (pause),
    .din     (op_rd),
    .dout    (row_en)
  );

endmodule

// File: tb/tb_systolic_array_ctrl.sv
`timescale 1ns/1ps
module tb_systolic_array_ctrl;

  localparam int N  = 4;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          op_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, pause, clear_acc, op_rd, out_valid;
  logic [KW-1:0] k_idx;
  logic [N-1:0]  row_en;
  logic [1:0]    out_row;

  always #5 clk = ~clk;

  systolic_array_ctrl #(.N(N), .K_WIDTH(KW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .k_len     (k_len),
    .op_valid  (op_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .pause     (pause),
    .clear_acc (clear_acc),
    .op_rd     (op_rd),
    .k_idx     (k_idx),
    .row_en    (row_en),
    .out_valid (out_valid),
    .out_row   (out_row)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pause;
    logic       clr;
    logic       rd;
    logic [7:0] kidx;
    logic [3:0] row;
    logic       ov;
    logic [1:0] orow;
  } outs_t;

  typedef struct {
    logic  op_valid;
    logic  out_ready;
    outs_t exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  vec_t tbl[22];

  function automatic outs_t sample();
    return outs_t'({busy, done, pause, clear_acc, op_rd, k_idx, row_en, out_valid, out_row});
  endfunction

  function automatic outs_t mk(input logic b, input logic d, input logic p, input logic c,
                               input logic r, input logic [7:0] k, input logic [3:0] re,
                               input logic ov, input logic [1:0] orw);
    return outs_t'({b, d, p, c, r, k, re, ov, orw});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Presents start for one sampling edge; afterwards we are in cycle 1.
  task automatic start_tile(input logic [KW-1:0] k);
    start = 1'b1;
    k_len = k;
    @(posedge clk); #1;
    start = 1'b0;
    k_len = 8'hA5;
    cyc = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    cyc++;
  endtask

  int first_done, n_done, bad;

  initial begin
    // Nominal tile, N=4 K=8: hand-derived per-cycle outputs
    //           busy done pause clr rd kidx row    ov orow
    tbl[0]  = '{1, 1, mk(1, 0, 0, 1, 0, 8'd0, 4'b0000, 0, 2'd0)};
    tbl[1]  = '{1, 1, mk(1, 0, 0, 0, 1, 8'd0, 4'b0001, 0, 2'd0)};
    tbl[2]  = '{1, 1, mk(1, 0, 0, 0, 1, 8'd1, 4'b0011, 0, 2'd0)};
    tbl[3]  = '{1, 1, mk(1, 0, 0, 0, 1, 8'd2, 4'b0111, 0, 2'd0)};
    tbl[4]  = '{1, 1, mk(1, 0, 0, 0, 1, 8'd3, 4'b1111, 0, 2'd0)};
    tbl[5]  = '{1, 1, mk(1, 0, 0, 0, 1, 8'd4, 4'b1111, 0, 2'd0)};
    tbl[6]  = '{1, 1, mk(1, 0, 0, 0, 1, 8'd5, 4'b1111, 0, 2'd0)};
    tbl[7]  = '{1, 1, mk(1, 0, 0, 0, 1, 8'd6, 4'b1111, 0, 2'd0)};
    tbl[8]  = '{1, 1, mk(1, 0, 0, 0, 1, 8'd7, 4'b1111, 0, 2'd0)};
    tbl[9]  = '{1, 1, mk(1, 0, 0, 0, 0, 8'd7, 4'b1110, 0, 2'd0)};
    tbl[10] = '{1, 1, mk(1, 0, 0, 0, 0, 8'd7, 4'b1100, 0, 2'd0)};
    tbl[11] = '{1, 1, mk(1, 0, 0, 0, 0, 8'd7, 4'b1000, 0, 2'd0)};
    tbl[12] = '{1, 1, mk(1, 0, 0, 0, 0, 8'd7, 4'b0000, 0, 2'd0)};
    tbl[13] = '{1, 1, mk(1, 0, 0, 0, 0, 8'd7, 4'b0000, 0, 2'd0)};
    tbl[14] = '{1, 1, mk(1, 0, 0, 0, 0, 8'd7, 4'b0000, 0, 2'd0)};
    tbl[15] = '{1, 1, mk(1, 0, 0, 0, 0, 8'd7, 4'b0000, 0, 2'd0)};
    tbl[16] = '{1, 1, mk(1, 0, 1, 0, 0, 8'd7, 4'b0000, 1, 2'd0)};
    tbl[17] = '{1, 1, mk(1, 0, 1, 0, 0, 8'd7, 4'b0000, 1, 2'd1)};
    tbl[18] = '{1, 1, mk(1, 0, 1, 0, 0, 8'd7, 4'b0000, 1, 2'd2)};
    tbl[19] = '{1, 1, mk(1, 0, 1, 0, 0, 8'd7, 4'b0000, 1, 2'd3)};
    tbl[20] = '{1, 1, mk(0, 1, 0, 0, 0, 8'd7, 4'b0000, 0, 2'd0)};
    tbl[21] = '{1, 1, mk(0, 0, 0, 0, 0, 8'd7, 4'b0000, 0, 2'd0)};

    // Reset state
    op_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("reset_outputs", 32'(sample()), 32'd0);
    reset_n = 1'b1;
    next_cycle();

    // 1: nominal tile
    start_tile(8'd8);
    for (int i = 0; i < 22; i++) begin
      op_valid  = tbl[i].op_valid;
      out_ready = tbl[i].out_ready;
      @(negedge clk);
      check("nominal", 32'(sample()), 32'(tbl[i].exp));
      next_cycle();
    end

    // 4: zero length
    start_tile(8'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cyc == 1) check("zero_done_c1", 32'({done, busy}), 32'(2'b10));
      if (cyc == 2) check("zero_done_c2", 32'(done), 32'd0);
      if (clear_acc || op_rd || out_valid) bad++;
      next_cycle();
    end
    check("zero_no_activity", 32'(bad), 32'd0);

    // 2: operand starvation, N=4 K=4, op_valid low in cycles 4..6
    start_tile(8'd4);
    first_done = 0;
    n_done = 0;
    while (cyc <= 30) begin
      op_valid = !(cyc >= 4 && cyc <= 6);
      @(negedge clk);
      if (cyc >= 4 && cyc <= 6) begin
        check("starve_pause", 32'(pause), 32'd1);
        check("starve_kidx", 32'(k_idx), 32'd2);
        check("starve_row_en", 32'(row_en), 32'b0110);
      end
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = cyc;
      end
      next_cycle();
    end
    op_valid = 1'b1;
    check("starve_done_cycle", 32'(first_done), 32'd20);
    check("starve_done_count", 32'(n_done), 32'd1);

    // 3: drain backpressure, N=4 K=2, out_ready low on odd cycles
    start_tile(8'd2);
    first_done = 0;
    n_done = 0;
    while (cyc <= 30) begin
      out_ready = (cyc % 2 == 0);
      @(negedge clk);
      if (cyc >= 11 && cyc <= 18)
        check("bp_drain", 32'({pause, out_valid, out_row}), 32'({1'b1, 1'b1, 2'((cyc - 11) / 2)}));
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = cyc;
      end
      next_cycle();
    end
    out_ready = 1'b1;
    check("bp_done_cycle", 32'(first_done), 32'd19);
    check("bp_done_count", 32'(n_done), 32'd1);

    // 6: start during FLUSH is ignored
    start_tile(8'd8);
    first_done = 0;
    n_done = 0;
    while (cyc <= 40) begin
      start = (cyc == 12);
      k_len = (cyc == 12) ? 8'd5 : 8'hA5;
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = cyc;
      end
      next_cycle();
    end
    start = 1'b0;
    check("busy_start_done_cycle", 32'(first_done), 32'd21);
    check("busy_start_done_count", 32'(n_done), 32'd1);

    // 5: reset during FEED at k_idx=3, then a fresh K=2 tile
    start_tile(8'd8);
    while (cyc < 5) next_cycle();
    @(negedge clk);
    check("rst_pre_kidx", 32'(k_idx), 32'd3);
    #1 reset_n = 1'b0;
    #1 check("rst_async_outputs", 32'(sample()), 32'd0);
    @(posedge clk); #1;
    check("rst_held_outputs", 32'(sample()), 32'd0);
    reset_n = 1'b1;
    next_cycle();
    start_tile(8'd2);
    first_done = 0;
    n_done = 0;
    while (cyc <= 25) begin
      @(negedge clk);
      if (cyc == 2) check("rst_kidx_c2", 32'({op_rd, k_idx}), 32'({1'b1, 8'd0}));
      if (cyc == 3) check("rst_kidx_c3", 32'({op_rd, k_idx}), 32'({1'b1, 8'd1}));
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = cyc;
      end
      next_cycle();
    end
    check("rst_done_cycle", 32'(first_done), 32'd15);
    check("rst_done_count", 32'(n_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array_ctrl.md
# systolic_array_ctrl

Sequencing controller for the N×N systolic array. It runs one tile computation: clears the PE accumulators, issues K operand steps, and freezes every PE input register through a single `pause` line whenever operands are not available. It generates the per-row skew-valid mask, flushes the wavefront, then drains results row by row under a valid/ready handshake. It sits between the operand buffers and the PE grid and is the only driver of the PE input-register `pause`.

## Interface
- `N`, 4, array dimension (rows = columns); N ≥ 2
- `K_WIDTH`, 8, width of the K-length and K-index fields
- `clk`  in  1  sole clock; all state updates on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a tile; sampled only in IDLE
- `k_len`  in  K_WIDTH  number of K steps; latched when `start` is accepted
- `op_valid`  in  1  operand buffers present one A-column/B-row slice this cycle
- `out_ready`  in  1  downstream accepts the current result row
- `busy`  out  1  high in CLEAR, FEED, FLUSH and DRAIN
- `done`  out  1  one-cycle pulse at tile completion
- `pause`  out  1  to all PE input registers; high means hold
- `clear_acc`  out  1  one-cycle accumulator clear
- `op_rd`  out  1  operand slice consumed this cycle
- `k_idx`  out  K_WIDTH  index of the slice being read
- `row_en`  out  N  skewed valid mask; bit i marks real data on row lane i
- `out_valid`  out  1  result row presented
- `out_row`  out  clog2(N)  index of the presented row

## Operation
- **States:** IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- **IDLE:**
  - `start` with `k_len` ≠ 0 → CLEAR.
  - `start` with `k_len` == 0 → DONE directly. The array is untouched.
- **CLEAR:** `clear_acc`=1 for one cycle; `k_idx` cleared → FEED.
- **FEED:**
  - `op_rd` = `op_valid`; `pause` = !`op_valid`.
  - `k_idx` increments on each `op_rd`.
  - When the `op_rd` with `k_idx` == `k_len`−1 occurs → FLUSH.
- **FLUSH:**
  - Lasts exactly 2N−1 cycles; `pause`=0.
  - No issue; zeros propagate in and the last wavefront reaches the bottom-right PE.
  - Then → DRAIN.
- **DRAIN:**
  - `pause`=1 (array frozen); `out_valid`=1; `out_row` starts at 0.
  - `out_row` increments on `out_valid`&`out_ready`.
  - Acceptance of row N−1 → DONE.
- **DONE:** `done`=1 for one cycle → IDLE.
- **Skew line:**
  - An N-stage shift register; stage 0 loads `op_rd`. `row_en[i]` is stage i.
  - It advances only when `pause`=0, so it freezes in lockstep with the PE registers.
  - It shifts in 0 during FLUSH and is cleared in CLEAR.
- **`start` outside IDLE:** ignored. `k_len` changes after acceptance have no effect.
- **Reset:** `reset_n` low at any time, including mid-FEED or mid-DRAIN, forces IDLE immediately. All outputs go to 0: `busy`, `done`, `pause`, `clear_acc`, `op_rd`, `k_idx`, `row_en`, `out_valid`, `out_row`.

## Timing
- Cycle t means the cycle after rising edge t; `start` is sampled at edge 0.
- With `op_valid` and `out_ready` held high, `k_len`=K and `N`=n:
  - CLEAR: cycle 1
  - FEED: cycles 2..K+1
  - FLUSH: next 2n−1 cycles
  - DRAIN: next n cycles
  - `done`: cycle 3n+K+1
- Each `op_valid` low cycle in FEED adds one cycle. Each `out_ready` low cycle in DRAIN adds one cycle.
- All outputs are registered or decoded from state; `row_en[0]` equals `op_rd` delayed by zero cycles (combinational from stage-0 input).
- `k_idx` never exceeds `k_len`−1. The counter wraps to 0 only via CLEAR.

## Structure
- Shared package `systolic_pkg`:
  - state encoding (6 states, 3 bits);
  - the FLUSH-length constant, 2N−1;
  - `clog2` helper.
- One sub-module, `skew_valid_line`: an N-bit delay line with synchronous clear, pause-hold and async active-low reset.
- Remaining logic lives in `systolic_array_ctrl`: FSM, K counter, flush counter, drain row counter.

## Test plan
1. **Nominal tile.** N=4, K=8, `op_valid`=`out_ready`=1, `start` at edge 0.
   - `clear_acc` in cycle 1; `op_rd` in cycles 2–9 with `k_idx` 0–7.
   - `row_en[3]` high in cycles 5–12; `out_valid` in cycles 17–20; `done` in cycle 21.
2. **Operand starvation.** N=4, K=4; `op_valid` low for 3 cycles after the 2nd slice.
   - `pause`=1 and `k_idx` holds at 2 for those 3 cycles.
   - `row_en` is frozen for those cycles.
   - `done` arrives 3 cycles later than the nominal case (cycle 20 instead of 17).
3. **Drain backpressure.** N=4, K=2; `out_ready` low on every other cycle.
   - `out_row` advances only on handshakes; rows 0–3 are each presented until accepted.
   - `pause` stays high throughout DRAIN; `done` arrives 4 cycles later than nominal.
4. **Zero length.** `start` with `k_len`=0 → `done` in cycle 1; `clear_acc`, `op_rd` and `out_valid` never assert.
5. **Reset mid-operation.** Assert `reset_n`=0 during FEED at `k_idx`=3.
   - All outputs go to 0 asynchronously.
   - After release, a new `start` with K=2 completes normally, with `k_idx` starting at 0.
6. **Start while busy.** Pulse `start` with `k_len`=5 during FLUSH of a K=8 run → ignored; exactly one `done`, timing unchanged.
